// File: rtl/serial_add_arbiter.sv
// Round-robin front end for one shared bit-serial full-adder slice.
// The winner's operands are summed LSB-first over WIDTH cycles; the result is tagged with its ID.
module serial_add_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             ack0,
  output logic             ack1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH:0]   sum
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic [WIDTH-1:0] r_acc;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic             r_owner;
  logic             r_lastGrant;

  logic             w_p;
  logic             w_g1;
  logic             w_s;
  logic             w_g2;
  logic             w_carryNext;
  logic             w_winner;
  logic [WIDTH-1:0] w_accNext;

  // Full adder built from two half adders plus the carry flip-flop.
  assign w_p         = r_opA[0] ^ r_opB[0];
  assign w_g1        = r_opA[0] & r_opB[0];
  assign w_s         = w_p ^ r_carry;
  assign w_g2        = w_p & r_carry;
  assign w_carryNext = w_g1 | w_g2;
  assign w_accNext   = {w_s, r_acc[WIDTH-1:1]};

  // Requester 1 wins when alone, or under contention when requester 0 had the last grant.
  assign w_winner = req1 & (~req0 | ~r_lastGrant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_opA       <= '0;
      r_opB       <= '0;
      r_acc       <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_owner     <= 1'b0;
      r_lastGrant <= 1'b1;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      done_id     <= 1'b0;
      sum         <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req0 | req1) begin
            r_opA       <= w_winner ? a1 : a0;
            r_opB       <= w_winner ? b1 : b0;
            r_acc       <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_owner     <= w_winner;
            r_lastGrant <= w_winner;
            ack0        <= ~w_winner;
            ack1        <= w_winner;
            busy        <= 1'b1;
            r_state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_acc   <= w_accNext;
          r_carry <= w_carryNext;
          r_opA   <= r_opA >> 1;
          r_opB   <= r_opB >> 1;
          r_idx   <= r_idx + 1'b1;
          if (r_idx == LastIdx) begin
            sum     <= {w_carryNext, w_accNext};
            done_id <= r_owner;
            done    <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
